// File: rtl/arbitro_memoria_tabuleiro_if.sv
// Board-memory arbiter bus: three requester lanes plus the single-port RAM side.
// slave = arbiter view, master = requesters/memory view.
interface arbitro_memoria_tabuleiro_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic [2:0]              req;
    logic [2:0]              we;
    logic [3*ADDR_WIDTH-1:0] addr;
    logic [3*DATA_WIDTH-1:0] wdata;
    logic [2:0]              gnt;
    logic [2:0]              valid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    ocupado;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic [3:0]              db_estado;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, valid, rdata, ocupado,
        output mem_en, mem_we, mem_addr, mem_wdata, db_estado
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, valid, rdata, ocupado,
        input  mem_en, mem_we, mem_addr, mem_wdata, db_estado
    );
endinterface

// File: rtl/arbitro_memoria_tabuleiro.sv
// Three-way arbiter for the single-port board RAM: game FSM, move comparator, display scanner.
// One access in flight; round-robin or fixed priority for requester 0.
module arbitro_memoria_tabuleiro #(
    parameter int ADDR_WIDTH      = 6,
    parameter int DATA_WIDTH      = 16,
    parameter int MEM_LATENCY     = 1,
    parameter int PRIORIDADE_FIXA = 0
) (
    input logic                        clock,
    input logic                        reset,
    arbitro_memoria_tabuleiro_if.slave bus
);
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CONCEDE = 2'd1,
        ESPERA  = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    estado_t               state_q, state_d;
    logic [1:0]            ultimo_q, ultimo_d;
    logic [1:0]            win_q, win_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [1:0] c1, c2, win;

    function automatic logic [1:0] mais1(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Search starts just after the last winner; fixed mode lets 0 pre-empt.
    always_comb begin
        c1 = mais1(ultimo_q);
        c2 = mais1(c1);
        win = mais1(c2);
        if (bus.req[c1]) begin
            win = c1;
        end else if (bus.req[c2]) begin
            win = c2;
        end
        if (PRIORIDADE_FIXA != 0 && bus.req[0]) begin
            win = 2'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= OCIOSO;
            ultimo_q <= 2'd2;
            win_q    <= 2'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= 3'd0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ultimo_q <= ultimo_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ultimo_d = ultimo_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        case (state_q)
            OCIOSO: begin
                if (|bus.req) begin
                    win_d   = win;
                    we_d    = bus.we[win];
                    addr_d  = bus.addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = bus.wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    state_d = CONCEDE;
                end
            end
            CONCEDE: begin
                ultimo_d = win_q;
                if (we_q) begin
                    state_d = OCIOSO;
                end else begin
                    state_d = ESPERA;
                    cnt_d   = 3'd1;
                end
            end
            ESPERA: begin
                if (cnt_q == LAT) begin
                    rdata_d = bus.mem_rdata;
                    state_d = ENTREGA;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ENTREGA: state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
    end

    always_comb begin
        case (state_q)
            OCIOSO:  bus.db_estado = 4'h0;
            CONCEDE: bus.db_estado = 4'h1;
            ESPERA:  bus.db_estado = 4'h2;
            ENTREGA: bus.db_estado = 4'h3;
            default: bus.db_estado = 4'hD;
        endcase
    end

    assign bus.gnt       = (state_q == CONCEDE) ? (3'b001 << win_q) : 3'b000;
    assign bus.valid     = (state_q == ENTREGA) ? (3'b001 << win_q) : 3'b000;
    assign bus.mem_en    = (state_q == CONCEDE);
    assign bus.mem_we    = (state_q == CONCEDE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.ocupado   = (state_q != OCIOSO);
endmodule
